uart_ctrl: RTL and testbench

UART_CTRL -- requirements
Module: uart_ctrl

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_fifo.sv | 48 ++++
 rtl/uart_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART controller.
// Holds the FSM state encoding used by both TX and RX, the parity_mode codes,
// the oversampling constants and a small parity helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

  // Tick counters must reach 2*OVERSAMPLE-1 for a two-stop-bit frame.
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] TICK_MID   = CNT_W'(MID_SAMPLE);
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] TICK_LAST2 = CNT_W'(2 * OVERSAMPLE - 1);

  // parity_mode codes; 2'b11 behaves as none.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used for both the TX and RX queues.
// Ports: clk/rst (sync, active-high), push/wdata write side, pop/rdata read
// side (rdata shows the head entry), full/empty status.
// Pushes on full and pops on empty are ignored.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Aw = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [Aw:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[Aw-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[Aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: baud generator, TX FIFO + transmitter, RX synchroniser +
// receiver + RX FIFO.
// Ports: clk/rst (sync, active-high); ubrr baud divisor (bit = 16*(ubrr+1)
// clocks); parity_mode/stop2 frame config; tx_data/tx_valid/tx_ready TX FIFO
// write; rx_data/rx_valid/rx_ready RX FIFO read; txd/rxd serial lines;
// rx_frame_err/rx_parity_err/rx_overrun one-cycle pulses; tx_busy.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned UBRR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [UBRR_W-1:0] ubrr,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              txd,
  input  logic              rxd,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun,
  output logic              tx_busy
);

  localparam logic [2:0] LastBit = 3'(DATA_W - 1);

  // Baud generator: >= keeps ticking sanely if ubrr shrinks mid-count.
  logic [UBRR_W-1:0] baud_cnt_q;
  logic              tick;
  assign tick = (baud_cnt_q >= ubrr);

  always_ff @(posedge clk) begin
    if (rst || tick) baud_cnt_q <= '0;
    else             baud_cnt_q <= baud_cnt_q + 1'b1;
  end

  // ---------------- Transmitter ----------------
  uart_state_e       tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d, tx_head;
  logic              tx_par_q, tx_par_d, tx_stop2_q, tx_stop2_d;
  logic [1:0]        tx_mode_q, tx_mode_d;
  logic              tx_load, tx_full, tx_empty;

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_valid), .wdata(tx_data), .pop(tx_load),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_mode_d  = tx_mode_q;
    tx_stop2_d = tx_stop2_q;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      StIdle: tx_load = tick && !tx_empty;
      StStart, StParity: if (tick) begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == TICK_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = (tx_state_q == StStart) ? StData : StStop;
        end
      end
      StData: if (tick) begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == TICK_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == LastBit) tx_state_d = parity_on(tx_mode_q) ? StParity : StStop;
        end
      end
      StStop: if (tick) begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == (tx_stop2_q ? TICK_LAST2 : TICK_LAST)) begin
          tx_cnt_d   = '0;
          tx_state_d = StIdle;
          tx_load    = !tx_empty;  // back-to-back frames skip IDLE
        end
      end
      default: tx_state_d = StIdle;
    endcase
    if (tx_load) begin
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ (parity_mode == PAR_ODD);
      tx_mode_d  = parity_mode;
      tx_stop2_d = stop2;
      tx_cnt_d   = '0;
      tx_state_d = StStart;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_mode_q  <= PAR_NONE;
      tx_stop2_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_mode_q  <= tx_mode_d;
      tx_stop2_q <= tx_stop2_d;
    end
  end

  assign txd = (tx_state_q == StStart)  ? 1'b0 :
               (tx_state_q == StData)   ? tx_shift_q[0] :
               (tx_state_q == StParity) ? tx_par_q : 1'b1;
  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_state_q != StIdle) || !tx_empty;

  // ---------------- Receiver ----------------
  logic              rx_sync1_q, rx_line_q, rx_prev_q;
  uart_state_e       rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_head;
  logic [1:0]        rx_mode_q, rx_mode_d;
  logic              rx_par_bad_q, rx_par_bad_d, rx_push_q, rx_push_d;
  logic              rx_ferr_q, rx_ferr_d, rx_perr_q, rx_perr_d;
  logic              rx_full, rx_empty;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_mode_d    = rx_mode_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_push_d    = 1'b0;
    rx_ferr_d    = 1'b0;
    rx_perr_d    = 1'b0;
    unique case (rx_state_q)
      StIdle: if (rx_prev_q && !rx_line_q) begin
        rx_state_d   = StStart;
        rx_cnt_d     = '0;
        rx_mode_d    = parity_mode;
        rx_par_bad_d = 1'b0;
      end
      StStart: if (tick) begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == TICK_MID && rx_line_q) begin
          rx_state_d = StIdle;  // false start
          rx_cnt_d   = '0;
        end else if (rx_cnt_q == TICK_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = StData;
        end
      end
      StData: if (tick) begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == TICK_MID) rx_shift_d = {rx_line_q, rx_shift_q[DATA_W-1:1]};
        if (rx_cnt_q == TICK_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == LastBit) rx_state_d = parity_on(rx_mode_q) ? StParity : StStop;
        end
      end
      StParity: if (tick) begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == TICK_MID)
          rx_par_bad_d = rx_line_q ^ (^rx_shift_q) ^ (rx_mode_q == PAR_ODD);
        if (rx_cnt_q == TICK_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = StStop;
        end
      end
      StStop: if (tick) begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        // Only the first stop bit is checked; return to IDLE mid-stop.
        if (rx_cnt_q == TICK_MID) begin
          rx_cnt_d   = '0;
          rx_state_d = StIdle;
          if (!rx_line_q)        rx_ferr_d = 1'b1;
          else if (rx_par_bad_q) rx_perr_d = 1'b1;
          else                   rx_push_d = 1'b1;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync1_q   <= 1'b1;
      rx_line_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= StIdle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_mode_q    <= PAR_NONE;
      rx_par_bad_q <= 1'b0;
      rx_push_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_perr_q    <= 1'b0;
    end else begin
      rx_sync1_q   <= rxd;
      rx_line_q    <= rx_sync1_q;
      rx_prev_q    <= rx_line_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_mode_q    <= rx_mode_d;
      rx_par_bad_q <= rx_par_bad_d;
      rx_push_q    <= rx_push_d;
      rx_ferr_q    <= rx_ferr_d;
      rx_perr_q    <= rx_perr_d;
    end
  end

  // rx_shift_q holds the word until the next frame's first data sample.
  uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push_q), .wdata(rx_shift_q), .pop(rx_ready),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign rx_valid      = !rx_empty;
  assign rx_data       = rx_valid ? rx_head : '0;
  assign rx_overrun    = rx_push_q && rx_full;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_perr_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: table of directly driven RX frames,
// TX waveform check, TX->RX loopback, RX overrun, false start and reset abort.
module tb_uart_ctrl;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned UBRR_W     = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [UBRR_W-1:0] ubrr = '0;
  logic [1:0]        parity_mode = 2'b00;
  logic              stop2 = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready = 1'b1;
  logic              txd, rxd;
  logic              rx_frame_err, rx_parity_err, rx_overrun, tx_busy;
  logic              loop_en = 1'b0;
  logic              rxd_drv = 1'b1;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_ctrl #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .UBRR_W(UBRR_W)) dut (
    .clk(clk), .rst(rst), .ubrr(ubrr), .parity_mode(parity_mode), .stop2(stop2),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .txd(txd), .rxd(rxd), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun), .tx_busy(tx_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_ferr  = 0;
  int n_perr  = 0;
  int n_ovr   = 0;
  int n_words = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: count pulses and compare every popped RX word.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_frame_err)  n_ferr++;
      if (rx_parity_err) n_perr++;
      if (rx_overrun)    n_ovr++;
      if (rx_valid && rx_ready) begin
        n_words++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected_word: got %0h, expected no word", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [DATA_W-1:0] d);
    int t = 0;
    while (!tx_ready && t < 5000) begin step(1); t++; end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic send_serial(input logic [DATA_W-1:0] d, input logic [1:0] pm,
                             input logic s2, input logic bad_stop, input logic bad_par,
                             input int bit_cyc);
    logic par;
    par = (^d) ^ (pm == 2'b10) ^ bad_par;
    parity_mode = pm;
    stop2 = s2;
    step(1);
    rxd_drv = 1'b0;
    step(bit_cyc);
    for (int i = 0; i < int'(DATA_W); i++) begin
      rxd_drv = d[i];
      step(bit_cyc);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      rxd_drv = par;
      step(bit_cyc);
    end
    rxd_drv = !bad_stop;
    step(bit_cyc);
    rxd_drv = 1'b1;
    if (s2) step(bit_cyc);
    step(3 * bit_cyc);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin step(1); t++; end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic       s2;
    logic       bad_stop;
    logic       bad_par;
    int         exp_word;
    int         exp_ferr;
    int         exp_perr;
  } rx_vec_t;

  rx_vec_t vecs [8];
  logic [7:0] lb_words [3];

  initial begin
    int w0, f0, p0, o0, t;
    logic [9:0] frame;

    vecs[0] = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vecs[1] = '{8'h55, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1, 0};
    vecs[2] = '{8'h01, 2'b10, 1'b0, 1'b0, 1'b1, 0, 0, 1};
    vecs[3] = '{8'hC3, 2'b01, 1'b1, 1'b0, 1'b0, 1, 0, 0};
    vecs[4] = '{8'h80, 2'b10, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vecs[5] = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vecs[6] = '{8'h00, 2'b01, 1'b0, 1'b0, 1'b1, 0, 0, 1};
    vecs[7] = '{8'hAA, 2'b01, 1'b0, 1'b1, 1'b0, 0, 1, 0};
    lb_words[0] = 8'h00;
    lb_words[1] = 8'hFF;
    lb_words[2] = 8'h3C;

    // Reset state
    step(3);
    @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_errs", 32'({rx_frame_err, rx_parity_err, rx_overrun}), 32'd0);
    step(1);
    rst = 1'b0;
    step(2);

    // Directly driven RX frames at ubrr=0
    for (int i = 0; i < 8; i++) begin
      w0 = n_words; f0 = n_ferr; p0 = n_perr;
      if (vecs[i].exp_word != 0) exp_q.push_back(vecs[i].data);
      send_serial(vecs[i].data, vecs[i].pm, vecs[i].s2, vecs[i].bad_stop, vecs[i].bad_par, 16);
      check($sformatf("rx_vec%0d_words", i), 32'(n_words - w0), 32'(vecs[i].exp_word));
      check($sformatf("rx_vec%0d_ferr", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("rx_vec%0d_perr", i), 32'(n_perr - p0), 32'(vecs[i].exp_perr));
      check($sformatf("rx_vec%0d_valid", i), 32'(rx_valid), 32'd0);
    end

    // TX waveform for 0xA5, 8N1, ubrr=0
    parity_mode = 2'b00; stop2 = 1'b0;
    frame = {1'b1, 8'hA5, 1'b0};
    tx_write(8'hA5);
    t = 0;
    while (txd !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    check("tx_start_seen", 32'(txd), 32'd0);
    t = 0;
    while (txd === 1'b0 && t < 40) begin @(negedge clk); t++; end
    check("tx_start_len", 32'(t), 32'd16);
    repeat (8) @(negedge clk);
    for (int k = 1; k < 10; k++) begin
      check($sformatf("tx_bit%0d", k), 32'(txd), 32'(frame[k]));
      repeat (16) @(negedge clk);
    end
    check("tx_idle_busy", 32'(tx_busy), 32'd0);
    check("tx_idle_txd", 32'(txd), 32'd1);

    // Loopback at ubrr=3, even parity, two stop bits
    step(1);
    ubrr = 12'd3; parity_mode = 2'b01; stop2 = 1'b1; loop_en = 1'b1;
    f0 = n_ferr; p0 = n_perr;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(lb_words[i]);
      tx_write(lb_words[i]);
    end
    wait_drain("lb_drain", 5000);
    check("lb_ferr", 32'(n_ferr - f0), 32'd0);
    check("lb_perr", 32'(n_perr - p0), 32'd0);
    t = 0;
    while (tx_busy && t < 500) begin step(1); t++; end
    check("lb_tx_done", 32'(tx_busy), 32'd0);
    step(8);
    loop_en = 1'b0;
    ubrr = '0;

    // RX overrun: FIFO_DEPTH+1 words with the reader stalled
    rx_ready = 1'b0;
    w0 = n_words; o0 = n_ovr;
    for (int i = 0; i <= int'(FIFO_DEPTH); i++) begin
      if (i < int'(FIFO_DEPTH)) exp_q.push_back(8'(i * 7 + 3));
      else check("ovr_before_last", 32'(n_ovr - o0), 32'd0);
      send_serial(8'(i * 7 + 3), 2'b00, 1'b0, 1'b0, 1'b0, 16);
    end
    check("ovr_pulses", 32'(n_ovr - o0), 32'd1);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_no_pops", 32'(n_words - w0), 32'd0);
    rx_ready = 1'b1;
    wait_drain("ovr_drain", 100);
    step(2);
    check("ovr_drained_words", 32'(n_words - w0), 32'(FIFO_DEPTH));
    check("ovr_empty", 32'(rx_valid), 32'd0);

    // False start: 4-cycle low glitch at ubrr=0
    w0 = n_words; f0 = n_ferr; p0 = n_perr;
    rxd_drv = 1'b0;
    step(4);
    rxd_drv = 1'b1;
    step(300);
    check("glitch_words", 32'(n_words - w0), 32'd0);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_ferr", 32'(n_ferr - f0), 32'd0);
    check("glitch_perr", 32'(n_perr - p0), 32'd0);

    // Reset in the middle of a TX frame
    tx_write(8'h00);
    t = 0;
    while (txd !== 1'b0 && t < 100) begin step(1); t++; end
    step(40);
    check("rst_mid_txd_low", 32'(txd), 32'd0);
    rst = 1'b1;
    step(1);
    check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    step(2);
    rst = 1'b0;
    step(40);
    check("rst_after_txd", 32'(txd), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
